freqmeas: RTL
=============

// Module: freqmeas
// PURPOSE
//   Measures an incoming slow periodic signal against the system clock. This is
//   the inverse of freqdiv: given a divided clock, it recovers the divisor
//   (period in clk cycles) and the high time.
//   It is used to self-check divider outputs and to measure external rhythm/tempo inputs.
//   Reports each completed period with a valid strobe, a lock flag and a stall flag.
// PARAMETERS
//   WIDTH        16  width of period/high_time counters; max measurable period 2^WIDTH-2
//   SYNC_STAGES  2   synchronizer flops on sig_in (>=2)
//   LOCK_N       4   consecutive identical periods required to assert locked (>=2)
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   sig_in     in   1      measured signal, asynchronous to clk
//   period     out  WIDTH  last measured period, clk cycles rise-to-rise
//   high_time  out  WIDTH  clk cycles the synced signal was high in that period
//   valid      out  1      1-cycle pulse: period/high_time just updated
//   locked     out  1      LOCK_N consecutive equal periods seen
//   stalled    out  1      no rising edge for 2^WIDTH-1 cycles
// BEHAVIOUR
//   Reset (async, any time): all outputs 0, sync chain 0, counters 0, state WAIT_FIRST.
//     Any partial measurement is discarded. There is no synchronous clear.
//   Sync and edge detect: s = last sync flop; s_d = s delayed 1 clk.
//     rise = s & ~s_d. The rise cycle is the clk cycle in which rise=1.
//   Counters: cnt and hcnt.
//     On a rise cycle: cnt<=1, hcnt<=1.
//     Otherwise: cnt<=cnt+1, hcnt<=hcnt+s. Both saturate at 2^WIDTH-1.
//     For rises at cycles t0 and t0+P, at the second rise: cnt==P, hcnt==cycles s high in [t0,t0+P).
//   FSM states:
//     WAIT_FIRST: rise -> MEASURE. No valid; counters restart.
//     MEASURE, on a rise:
//       period<=cnt, high_time<=hcnt, valid=1 on the next cycle; stay in MEASURE.
//     MEASURE, on cnt reaching 2^WIDTH-1 with no rise:
//       -> STALL. stalled<=1, locked<=0. period/high_time hold their last values; no valid.
//     STALL: rise -> MEASURE, stalled<=0 on the next cycle.
//       That rise is a fresh first edge; no valid is produced.
//     WAIT_FIRST also goes to STALL if cnt saturates.
//   Lock:
//     match_cnt increments (saturating at LOCK_N) on each valid whose new period equals the previous one.
//     The first valid after WAIT_FIRST/STALL sets match_cnt=1.
//     A differing period sets match_cnt=1 and locked<=0.
//     locked = (match_cnt==LOCK_N), registered, updated in the same cycle as valid.
//   Latency: sig_in rise to valid is SYNC_STAGES+1 to SYNC_STAGES+2 clk cycles (sync metastability window).
//   Minimum measurable period: 2 cycles (1 high, 1 low). Glitches shorter than 1 clk may be lost.
//   high_time==period is impossible; high_time==0 is impossible while in MEASURE.
// TESTING
//   1. Reset held, sig_in toggling -> all outputs 0.
//      Release reset -> first rise gives no valid; second rise gives valid with the correct period.
//   2. sig_in from freqdiv #(2), #(3), #(4) -> period=2/3/4 and high_time=1/1or2/2 (match divider duty).
//      locked=1 after the 4th equal valid.
//   3. Drive period 10 (high 3) x5, then period 12 -> locked drops on the period=12 valid.
//      high_time=3 before the change.
//   4. WIDTH=8, hold sig_in low -> stalled=1 after 255 cycles with no valid; period keeps its old value.
//      Next two rises -> stalled=0, then a single valid.
//   5. Assert reset mid-period (cnt=7) -> outputs 0 immediately, asynchronously.
//      After release, the first rise yields no valid.
//   6. Period 2 (1 high/1 low) continuous -> valid every 2 cycles, period=2, high_time=1, locked after LOCK_N.

Source files
------------

// File: rtl/freqmeas.sv
// freqmeas: measures the period (rise to rise) and high time of a slow,
// asynchronous periodic signal in system clock cycles. It also reports
// when the period is stable (locked) and when the signal has stopped (stalled).
module freqmeas #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_N      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             stalled
);

  localparam int MW = $clog2(LOCK_N + 1);

  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
  localparam logic [MW-1:0]    MATCH_FULL = MW'(LOCK_N);

  localparam logic [1:0] WAIT_FIRST = 2'd0;
  localparam logic [1:0] MEASURE    = 2'd1;
  localparam logic [1:0] STALL      = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       hcnt;
  logic [1:0]             state;
  logic [MW-1:0]          match_cnt;
  logic [MW-1:0]          next_match;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // Synchronizer chain and one-cycle delay of the synced signal for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  // Period and high-time counters: restart at 1 on each rise, otherwise count up and saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= CNT_ONE;
      hcnt <= CNT_ONE;
    end else begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
      if (hcnt != CNT_MAX) begin
        hcnt <= hcnt + {{(WIDTH-1){1'b0}}, s};
      end
    end
  end

  // Match count a new measurement would produce; zero means no previous period to compare with.
  always_comb begin
    next_match = MATCH_ONE;
    if ((match_cnt != '0) && (cnt == period)) begin
      next_match = (match_cnt == MATCH_FULL) ? MATCH_FULL : match_cnt + MATCH_ONE;
    end
  end

  // Measurement FSM: captures results on each rise, tracks lock, and detects a stopped input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_FIRST;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      stalled   <= 1'b0;
      match_cnt <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          if (rise) begin
            state     <= MEASURE;
            match_cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= STALL;
            stalled   <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period    <= cnt;
            high_time <= hcnt;
            valid     <= 1'b1;
            match_cnt <= next_match;
            locked    <= (next_match == MATCH_FULL);
          end else if (cnt == CNT_MAX) begin
            state     <= STALL;
            stalled   <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        end
        STALL: begin
          if (rise) begin
            state     <= MEASURE;
            stalled   <= 1'b0;
            match_cnt <= '0;
          end
        end
        default: begin
          state <= WAIT_FIRST;
        end
      endcase
    end
  end

endmodule
